// File: rtl/pc_sequencer_if.sv
// Bus bundle between the fetch/branch pipeline and the PC sequencer.
// The pipeline side (master) supplies candidate PCs, select controls and
// interrupt requests; the sequencer side (slave) returns the next PC and
// interrupt status.
interface pc_sequencer_if #(
    parameter int PC_W    = 32,
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
);
    // interrupt sources
    logic [NUM_IRQ-1:0] irq_req;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               global_ie;

    // candidate next-PC values
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus_4;
    logic [PC_W-1:0]    branch_pc;
    logic [PC_W-1:0]    pc_not_taken;
    logic [PC_W-1:0]    pcr;
    logic [PC_W-1:0]    pci;

    // normal-select controls and interrupt return
    logic               stall;
    logic               branch_undo;
    logic               pcr_take;
    logic               branch_predict;
    logic               pci_take;
    logic               iret;

    // sequencer results
    logic [PC_W-1:0]    pc_out;
    logic               flush;
    logic               interrupt;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [ID_W-1:0]    irq_id;
    logic [PC_W-1:0]    epc;
    logic               in_service;

    modport master (
        output irq_req, irq_mask, global_ie,
        output pc, pc_plus_4, branch_pc, pc_not_taken, pcr, pci,
        output stall, branch_undo, pcr_take, branch_predict, pci_take, iret,
        input  pc_out, flush, interrupt, irq_ack, irq_id, epc, in_service
    );

    modport slave (
        input  irq_req, irq_mask, global_ie,
        input  pc, pc_plus_4, branch_pc, pc_not_taken, pcr, pci,
        input  stall, branch_undo, pcr_take, branch_predict, pci_take, iret,
        output pc_out, flush, interrupt, irq_ack, irq_id, epc, in_service
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer with non-nesting interrupt entry.
// IDLE passes the prioritised normal PC select through. An accepted
// interrupt saves the return PC, holds the pipeline in FLUSH for
// FLUSH_CYCLES cycles (the last one steers to the handler vector) and then
// sits in SERVICE until an unstalled iret restores the saved PC.
// Status outputs decode only from registered state, never from inputs.
module pc_sequencer #(
    parameter int          PC_W         = 32,
    parameter int          NUM_IRQ      = 4,
    parameter int          FLUSH_CYCLES = 4,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE   = 32'h0000_0010
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

    localparam int ID_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;
    localparam int VEC_W = (PC_W > 32) ? PC_W : 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FLUSH   = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

    // Lowest-index set bit of the pending vector (bit 0 wins).
    function automatic logic [ID_W-1:0] first_pending(input logic [NUM_IRQ-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = {ID_W{1'b0}};
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [ID_W-1:0]    irq_id_r;
    logic [PC_W-1:0]    epc_r;

    logic [NUM_IRQ-1:0] pend_s;
    logic               take_irq_s;
    logic               enter_s;
    logic               last_s;
    logic [PC_W-1:0]    normal_pc_s;
    logic [VEC_W-1:0]   vec_full_s;
    logic [PC_W-1:0]    pc_vec_s;
    logic [PC_W-1:0]    pc_sel_s;
    logic               flush_s;
    logic               interrupt_s;
    logic [NUM_IRQ-1:0] irq_ack_s;
    logic               in_service_s;

    // Unmasked pending requests, gated by the global enable.
    always_comb begin
        pend_s     = bus.irq_req & ~bus.irq_mask;
        take_irq_s = bus.global_ie && (|pend_s);
    end

    // Prioritised normal PC select; stall freezes the PC above everything.
    always_comb begin
        if (bus.stall) begin
            normal_pc_s = bus.pc;
        end else if (bus.branch_undo) begin
            normal_pc_s = bus.pc_not_taken;
        end else if (bus.pcr_take) begin
            normal_pc_s = bus.pcr;
        end else if (bus.branch_predict) begin
            normal_pc_s = bus.branch_pc;
        end else if (bus.pci_take) begin
            normal_pc_s = bus.pci;
        end else begin
            normal_pc_s = bus.pc_plus_4;
        end
    end

    // Handler vector for the latched channel, wrapped to the PC width.
    always_comb begin
        vec_full_s = VEC_W'(VEC_BASE) + (VEC_W'(irq_id_r) * VEC_W'(VEC_STRIDE));
        pc_vec_s   = vec_full_s[PC_W-1:0];
        last_s     = (cnt_r == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-PC decode.
    always_comb begin
        state_nxt_s = state_r;
        pc_sel_s    = normal_pc_s;
        enter_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // iret is meaningless here; stall does not block entry
                if (take_irq_s) begin
                    state_nxt_s = ST_FLUSH;
                    enter_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (last_s) begin
                    pc_sel_s    = pc_vec_s;
                    state_nxt_s = ST_SERVICE;
                end else begin
                    pc_sel_s    = bus.pc;
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_SERVICE: begin
                // a stalled iret keeps the normal select (which yields pc)
                if (bus.iret && !bus.stall) begin
                    pc_sel_s    = epc_r;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Flush counter, serviced id and return PC; captured on the entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            irq_id_r <= {ID_W{1'b0}};
            epc_r    <= {PC_W{1'b0}};
        end else if (enter_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            irq_id_r <= first_pending(pend_s);
            epc_r    <= pc_sel_s;
        end else if (state_r == ST_FLUSH) begin
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r    <= cnt_r;
        end
    end

    // Status outputs decoded from state and counter only.
    always_comb begin
        flush_s      = 1'b0;
        interrupt_s  = 1'b0;
        in_service_s = 1'b0;
        irq_ack_s    = {NUM_IRQ{1'b0}};
        case (state_r)
            ST_FLUSH: begin
                flush_s     = 1'b1;
                interrupt_s = last_s;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    irq_ack_s[i] = last_s && (irq_id_r == ID_W'(i));
                end
            end
            ST_SERVICE: begin
                in_service_s = 1'b1;
            end
            default: begin
                flush_s = 1'b0;
            end
        endcase
    end

    assign bus.pc_out     = pc_sel_s;
    assign bus.flush      = flush_s;
    assign bus.interrupt  = interrupt_s;
    assign bus.irq_ack    = irq_ack_s;
    assign bus.in_service = in_service_s;
    assign bus.irq_id     = irq_id_r;
    assign bus.epc        = epc_r;

endmodule
